// File: rtl/deadlock_mon_pkg.sv
// ============================================================================
// deadlock_mon_pkg : shared types and helpers for the kernel deadlock monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WATCH   = 2'd1,
    ST_BLOCKED = 2'd2
  } dd_state_t;

  // Index width that leaves room for an all-ones "no bit set" code.
  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic [31:0] idx_none(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc_lsb.sv
// ============================================================================
// prio_enc_lsb : lowest-set-bit priority encoder with valid flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module prio_enc_lsb
  import deadlock_mon_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  localparam logic [IDX_W-1:0] C_IDX_NONE = IDX_W'(idx_none(IDX_W));

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    idx   = C_IDX_NONE;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/kernel_deadlock_detector.sv
// ============================================================================
// kernel_deadlock_detector : sticky per-kernel stall detector with port snapshot
// Revision: 1.0
// ============================================================================
`default_nettype none

module kernel_deadlock_detector
  import deadlock_mon_pkg::*;
#(
  parameter int NUM_AXIS    = 3,
  parameter int NUM_INST    = 3,
  parameter int NUM_BLK     = 1,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_AXIS-1:0]       axis_block_sigs,
  input  logic [NUM_INST-1:0]       inst_idle_sigs,
  input  logic [NUM_BLK-1:0]        inst_block_sigs,
  input  logic                      clear,
  output logic                      block,
  output logic                      block_pulse,
  output logic [NUM_AXIS-1:0]       axis_snapshot,
  output logic [$clog2(NUM_AXIS):0] first_axis_idx,
  output logic [CNT_W-1:0]          stall_cycles
);

  localparam int               IDX_W      = $clog2(NUM_AXIS) + 1;
  localparam logic [IDX_W-1:0] C_IDX_NONE = IDX_W'(idx_none(IDX_W));
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_HOLD_M1  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

  logic [NUM_AXIS-1:0] r_axis_q;
  logic [NUM_AXIS-1:0] r_axis_prev;
  logic [NUM_INST-1:0] r_idle_q;
  logic [NUM_INST-1:0] r_idle_prev;
  logic [NUM_BLK-1:0]  r_blk_q;
  dd_state_t           r_state;

  logic                w_any_blk;
  logic                w_progress;
  logic                w_stall;
  logic [IDX_W-1:0]    w_enc_idx;
  logic                w_enc_valid;

  assign w_any_blk  = (|r_axis_q) | (|r_blk_q);
  assign w_progress = (r_axis_q != r_axis_prev) || (r_idle_q != r_idle_prev);
  assign w_stall    = w_any_blk & ~w_progress;

  prio_enc_lsb #(
    .WIDTH (NUM_AXIS),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec   (r_axis_q),
    .idx   (w_enc_idx),
    .valid (w_enc_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_axis_q       <= '0;
      r_axis_prev    <= '0;
      r_idle_q       <= '0;
      r_idle_prev    <= '0;
      r_blk_q        <= '0;
      r_state        <= ST_IDLE;
      stall_cycles   <= '0;
      block          <= 1'b0;
      block_pulse    <= 1'b0;
      axis_snapshot  <= '0;
      first_axis_idx <= C_IDX_NONE;
    end else begin
      r_axis_q    <= axis_block_sigs;
      r_axis_prev <= r_axis_q;
      r_idle_q    <= inst_idle_sigs;
      r_idle_prev <= r_idle_q;
      r_blk_q     <= inst_block_sigs;
      block_pulse <= 1'b0;

      // Clear outranks everything, including a same-cycle detection.
      if (clear) begin
        r_state        <= ST_IDLE;
        stall_cycles   <= '0;
        block          <= 1'b0;
        axis_snapshot  <= '0;
        first_axis_idx <= C_IDX_NONE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_stall) begin
              r_state      <= ST_WATCH;
              stall_cycles <= C_CNT_ONE;
            end else begin
              stall_cycles <= '0;
            end
          end
          ST_WATCH: begin
            if (w_stall) begin
              stall_cycles <= stall_cycles + C_CNT_ONE;
              if (stall_cycles == C_HOLD_M1) begin
                r_state        <= ST_BLOCKED;
                block          <= 1'b1;
                block_pulse    <= 1'b1;
                axis_snapshot  <= r_axis_q;
                first_axis_idx <= w_enc_valid ? w_enc_idx : C_IDX_NONE;
              end
            end else begin
              r_state      <= ST_IDLE;
              stall_cycles <= '0;
            end
          end
          ST_BLOCKED: begin
            if (w_stall) begin
              if (stall_cycles != C_CNT_MAX) begin
                stall_cycles <= stall_cycles + C_CNT_ONE;
              end
            end else begin
              stall_cycles <= '0;
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            stall_cycles <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kernel_deadlock_detector.sv
// Bench for kernel_deadlock_detector: run-length reference model checked every
// cycle, plus directed scenarios with hand-derived latencies.
`default_nettype none

module tb_kernel_deadlock_detector;

  localparam int HOLD = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] axis  = '0;
  logic [2:0] idle  = '0;
  logic [0:0] blk   = '0;
  logic       clear = 1'b0;
  logic       block;
  logic       block_pulse;
  logic [2:0] axis_snapshot;
  logic [2:0] first_axis_idx;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  kernel_deadlock_detector #(
    .NUM_AXIS(3), .NUM_INST(3), .NUM_BLK(1), .HOLD_CYCLES(HOLD), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(blk), .clear(clear), .block(block), .block_pulse(block_pulse),
    .axis_snapshot(axis_snapshot), .first_axis_idx(first_axis_idx),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] lowest_idx(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return 3'(i);
    return 3'b111;
  endfunction

  // Reference model: what the kernel looked like one and two samples ago,
  // and how long the current unbroken stall run is.
  logic [2:0] seen_a, older_a, seen_i, older_i;
  logic [0:0] seen_b;
  int         run;
  logic       m_blocked, m_pulse;
  logic [2:0] m_snap;

  initial begin
    seen_a = 0; older_a = 0; seen_i = 0; older_i = 0; seen_b = 0;
    run = 0; m_blocked = 0; m_pulse = 0; m_snap = 0;
    forever begin
      logic stalled;
      @(posedge clock);
      stalled = ((seen_a != 0) || (seen_b != 0)) && seen_a == older_a && seen_i == older_i;
      m_pulse = 1'b0;
      if (reset) begin
        seen_a = 0; older_a = 0; seen_i = 0; older_i = 0; seen_b = 0;
        run = 0; m_blocked = 0; m_snap = 0;
      end else begin
        if (clear) begin
          run = 0; m_blocked = 0; m_snap = 0;
        end else if (!stalled) begin
          run = 0;
        end else if (m_blocked) begin
          if (run < 65535) run++;
        end else begin
          run++;
          if (run == HOLD) begin
            m_blocked = 1; m_pulse = 1; m_snap = seen_a;
          end
        end
        older_a = seen_a; older_i = seen_i;
        seen_a = axis; seen_i = idle; seen_b = blk;
      end
      #1;
      check("m_block", 32'(block), 32'(m_blocked));
      check("m_pulse", 32'(block_pulse), 32'(m_pulse));
      check("m_snap", 32'(axis_snapshot), 32'(m_snap));
      check("m_idx", 32'(first_axis_idx), 32'(lowest_idx(m_snap)));
      check("m_cnt", 32'(stall_cycles), 32'(run));
    end
  end

  // Counts rising edges until block is seen, bounded.
  task automatic wait_block(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clock); #1;
      n++;
      if (block) return;
    end
    total++; bad++;
    $display("FAIL wait_block: no block within %0d cycles", limit);
  endtask

  task automatic clean();
    @(negedge clock);
    axis = 0; idle = 0; blk = 0; clear = 1;
    @(negedge clock);
    clear = 0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int n;
    logic seen;
    repeat (3) @(posedge clock);
    #1;
    check("rst_block", 32'(block), 0);
    check("rst_pulse", 32'(block_pulse), 0);
    check("rst_snap", 32'(axis_snapshot), 0);
    check("rst_idx", 32'(first_axis_idx), 32'h7);
    check("rst_cnt", 32'(stall_cycles), 0);
    @(negedge clock); reset = 0;
    repeat (3) @(negedge clock);

    // Constant 010 stall
    axis = 3'b010;
    wait_block(40, n);
    check("t1_latency", 32'(n), 18);
    check("t1_pulse", 32'(block_pulse), 1);
    check("t1_snap", 32'(axis_snapshot), 32'b010);
    check("t1_idx", 32'(first_axis_idx), 1);
    @(posedge clock); #1;
    check("t1_pulse_gone", 32'(block_pulse), 0);
    check("t1_block_held", 32'(block), 1);

    // Short window, one-cycle gap, long window
    clean();
    axis = 3'b100;
    seen = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (block) seen = 1;
    end
    check("t2_cnt_w1", 32'(stall_cycles), 8);
    @(negedge clock); axis = 0;
    @(posedge clock); #1; if (block) seen = 1;
    @(negedge clock); axis = 3'b100;
    @(posedge clock); #1; if (block) seen = 1;
    check("t2_no_block_w1", 32'(seen), 0);
    check("t2_cnt_zero", 32'(stall_cycles), 0);
    wait_block(40, n);
    check("t2_latency", 32'(n + 1), 18);

    // Idle toggling keeps resetting the run
    clean();
    axis = 3'b001;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (c % 5 == 0) idle = (idle == 3'b010) ? 3'b000 : 3'b010;
      @(posedge clock); #1;
      if (block) seen = 1;
      @(negedge clock);
    end
    check("t3_never_block", 32'(seen), 0);

    // Snapshot frozen after stall goes away, then clear
    clean();
    axis = 3'b011;
    wait_block(40, n);
    check("t4_latency", 32'(n), 18);
    @(negedge clock); axis = 0;
    repeat (3) @(posedge clock);
    #1;
    check("t4_block_held", 32'(block), 1);
    check("t4_snap_held", 32'(axis_snapshot), 32'b011);
    check("t4_idx_held", 32'(first_axis_idx), 0);
    check("t4_cnt_zero", 32'(stall_cycles), 0);
    @(negedge clock); clear = 1;
    @(posedge clock); #1;
    check("t4_clr_block", 32'(block), 0);
    check("t4_clr_snap", 32'(axis_snapshot), 0);
    check("t4_clr_idx", 32'(first_axis_idx), 32'h7);
    @(negedge clock); clear = 0;

    // Clear on the detecting edge
    clean();
    axis = 3'b010;
    repeat (17) @(posedge clock);
    #1;
    check("t5_cnt15", 32'(stall_cycles), 15);
    @(negedge clock); clear = 1;
    @(posedge clock); #1;
    check("t5_no_block", 32'(block), 0);
    check("t5_no_pulse", 32'(block_pulse), 0);
    @(negedge clock); clear = 0;
    wait_block(40, n);
    check("t5_relatency", 32'(n), HOLD);

    // Reset mid-watch
    clean();
    axis = 3'b010;
    repeat (11) @(posedge clock);
    #1;
    check("t6_cnt9", 32'(stall_cycles), 9);
    @(negedge clock); reset = 1;
    @(posedge clock); #1;
    check("t6_rst_cnt", 32'(stall_cycles), 0);
    check("t6_rst_idx", 32'(first_axis_idx), 32'h7);
    check("t6_rst_block", 32'(block), 0);
    @(negedge clock); reset = 0;
    wait_block(40, n);
    check("t6_latency", 32'(n), 18);

    // Randomized traffic; the model checks every cycle
    clean();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 11) == 0) axis = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) idle = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) blk = ~blk;
      clear = ($urandom_range(0, 79) == 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clock); clear = 0; reset = 0;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
